uart_load_ctrl: RTL and testbench
=================================

// Module: uart_load_ctrl
// PURPOSE
//  Frame controller behind the UART byte-to-word assembler.
//  - Parses a header word, then steers the following N payload words into one of N_TGT
//    on-chip memories (image buffer, layer weights, biases) with auto-incrementing addresses.
//  - Flags framing errors and watchdog timeouts; pulses start_infer after a complete image.
//  - Sits between the UART word assembler and the DNN memory write ports.
// PARAMETERS
//  DATA_W   16         payload word width
//  ADDR_W   12         memory address width; max frame length 2^ADDR_W-1 words
//  N_TGT    4          number of target memories; target 0 is the image buffer
//  TIMEOUT  1_000_000  idle clk cycles tolerated between words inside a frame
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  word_valid   in   1        single-cycle strobe: word holds a new assembled word
//  word         in   DATA_W   assembled word (header or payload)
//  infer_busy   in   1        DNN core running; image buffer must not be overwritten
//  wr_en        out  1        memory write strobe
//  wr_sel       out  N_TGT    one-hot target-memory select, valid with wr_en
//  wr_addr      out  ADDR_W   write address, 0..N-1 within the frame
//  wr_data      out  DATA_W   write data
//  busy         out  1        high from header acceptance until frame end or abort
//  load_done    out  1        1-cycle pulse: frame completed without error
//  done_tgt     out  2        target id of the last completed frame; held until next completion
//  start_infer  out  1        1-cycle pulse, coincident with load_done when done_tgt==0
//  err          out  1        1-cycle pulse on any error
//  err_code     out  3        last error, sticky until next accepted header:
//                             0 none, 1 bad target, 2 zero length, 3 busy, 4 timeout
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters 0.
//  - Writes already made to memory are not undone by reset or abort.
//  - All outputs are registered.
//  - Header format: word[15:12] = target id; word[11:0] = N, the number of payload words.
//  - IDLE, on word_valid (header):
//      tgt >= N_TGT                 -> err, code 1, stay IDLE
//      N == 0                       -> err, code 2, stay IDLE
//      tgt == 0 and infer_busy == 1 -> err, code 3, go to SKIP (discard N words to keep framing)
//      otherwise                    -> err_code <= 0, latch tgt/N, addr <= 0, busy <= 1,
//                                      go to LOAD
//  - LOAD, each word_valid at cycle t:
//      wr_en=1 at t+1, wr_sel=onehot(tgt), wr_addr=addr, wr_data=word; addr increments.
//      On the Nth word, go to FINISH.
//  - FINISH (1 cycle):
//      load_done=1, done_tgt=tgt, start_infer=(tgt==0), busy <= 0; go to IDLE.
//      Timing: last payload word_valid at t -> wr_en at t+1, load_done at t+2.
//  - SKIP: count N words without writing; busy stays 1. On the Nth word, busy <= 0 and go
//    to IDLE; no load_done pulse.
//  - Watchdog (LOAD/SKIP only):
//      Counter cleared by every word_valid and on state entry.
//      When it reaches TIMEOUT-1: err, code 4, busy <= 0, go to IDLE.
//      If word_valid and expiry fall on the same cycle, the word wins (accepted, counter cleared).
//  - infer_busy rising during a LOAD to target 0 is ignored; it is checked only at header time.
//  - word_valid on the cycle of FINISH is treated as a new header (FINISH also evaluates the
//    IDLE header rules).
//  - Address never wraps: at most 4095 payload words; the counter width is ADDR_W.
// STRUCTURE
//  Shared package (uart_load_pkg):
//    - target ids: TGT_IMG=0, TGT_W1=1, TGT_W2=2, TGT_B=3
//    - err codes: ERR_NONE..ERR_TIMEOUT
//    - state encodings: IDLE, LOAD, SKIP, FINISH
//    - header field positions
//  Sub-module load_watchdog: counter with clear and enable inputs; expire output after
//    TIMEOUT-1 cycles.
//  The FSM, address counter and output registers stay in this module.
// TESTING (bench uses TIMEOUT=50)
//  1. Header 0x1003, then payload words 0xAAAA, 0xBBBB, 0xCCCC
//       -> wr_sel=0010 at addr 0,1,2 with that data; load_done, done_tgt=1; no start_infer.
//  2. Header 0x0002 with infer_busy=0, then 2 payload words
//       -> writes to wr_sel=0001; load_done and start_infer pulse in the same cycle.
//  3. Header 0x0002 with infer_busy=1, then 2 words, then header 0x2001 and 1 word
//       -> err code 3; no wr_en for the 2 words; second frame loads target 2 at addr 0.
//  4. Header 0x5001 -> err code 1. Header 0x1000 -> err code 2. Both stay IDLE; no wr_en.
//  5. Header 0x1004, 2 payload words, then 50 idle cycles
//       -> err code 4; busy falls; the next header is accepted normally.
//  6. Assert rst_n low mid-LOAD (after 1 of 3 words)
//       -> all outputs 0 immediately; a fresh header 0x3001 loads at addr 0.

Source files
------------

// File: rtl/uart_load_pkg.sv
// Shared constants for the UART frame loader: target ids, error codes,
// FSM state encodings and header field positions.
package uart_load_pkg;

  // Target memory ids (target 0 is the image buffer)
  localparam logic [1:0] TGT_IMG = 2'd0;
  localparam logic [1:0] TGT_W1  = 2'd1;
  localparam logic [1:0] TGT_W2  = 2'd2;
  localparam logic [1:0] TGT_B   = 2'd3;

  // Error codes reported on err_code
  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_TGT  = 3'd1;
  localparam logic [2:0] ERR_ZERO_LEN = 3'd2;
  localparam logic [2:0] ERR_BUSY     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SKIP   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // Header word layout: [15:12] target id, [11:0] payload length
  localparam int HDR_TGT_MSB = 15;
  localparam int HDR_TGT_LSB = 12;
  localparam int HDR_LEN_MSB = 11;
  localparam int HDR_LEN_LSB = 0;

endpackage

// File: rtl/load_watchdog.sv
// Inter-word idle watchdog: counts enabled cycles since the last clear and
// flags expiry once the count reaches TIMEOUT-1. The count saturates there.
module load_watchdog #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_reg;

  assign expire = (cnt_reg == CNT_W'(TIMEOUT - 1));

  // Idle counter: clear wins, otherwise count while enabled until expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && !expire) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_load_ctrl.sv
// Frame controller behind the UART word assembler: parses a header, steers the
// following payload words into one of N_TGT memories with auto-incrementing
// addresses, reports framing errors / timeouts and triggers inference after a
// complete image load.
module uart_load_ctrl
  import uart_load_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 12,
  parameter int N_TGT   = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word,
  input  logic              infer_busy,
  output logic              wr_en,
  output logic [N_TGT-1:0]  wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              load_done,
  output logic [1:0]        done_tgt,
  output logic              start_infer,
  output logic              err,
  output logic [2:0]        err_code
);

  logic [1:0]        state_reg, state_next;
  logic [1:0]        tgt_reg;
  logic [ADDR_W-1:0] len_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic              wr_en_reg, busy_reg, load_done_reg, start_infer_reg, err_reg;
  logic [N_TGT-1:0]  wr_sel_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [1:0]        done_tgt_reg;
  logic [2:0]        err_code_reg;

  logic [3:0]        hdr_tgt;
  logic [ADDR_W-1:0] hdr_len;
  logic [2:0]        hdr_code;
  logic [N_TGT-1:0]  sel_onehot;
  logic              in_frame, last_word, wd_expire, timeout;

  assign hdr_tgt = word[HDR_TGT_MSB:HDR_TGT_LSB];
  assign hdr_len = ADDR_W'(word[HDR_LEN_MSB:HDR_LEN_LSB]);

  // Header classification, in priority order: bad target, zero length, image busy
  always_comb begin
    hdr_code = ERR_NONE;
    if (32'(hdr_tgt) >= N_TGT)
      hdr_code = ERR_BAD_TGT;
    else if (hdr_len == '0)
      hdr_code = ERR_ZERO_LEN;
    else if (hdr_tgt == 4'(TGT_IMG) && infer_busy)
      hdr_code = ERR_BUSY;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_TGT; gi++) begin : g_sel
      assign sel_onehot[gi] = (32'(tgt_reg) == gi);
    end
  endgenerate

  assign in_frame  = (state_reg == ST_LOAD) || (state_reg == ST_SKIP);
  assign last_word = (addr_reg == len_reg - 1'b1);
  // A word arriving on the expiry cycle takes precedence over the timeout
  assign timeout   = in_frame && wd_expire && !word_valid;

  // Watchdog is held clear outside a frame, so every frame entry starts from 0
  load_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (word_valid || !in_frame),
    .en     (in_frame),
    .expire (wd_expire)
  );

  // Next-state logic; FINISH doubles as IDLE for header acceptance
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_FINISH: begin
        state_next = ST_IDLE;
        if (word_valid) begin
          if (hdr_code == ERR_NONE)      state_next = ST_LOAD;
          else if (hdr_code == ERR_BUSY) state_next = ST_SKIP;
        end
      end
      ST_LOAD: begin
        if (word_valid && last_word) state_next = ST_FINISH;
        else if (timeout)            state_next = ST_IDLE;
      end
      ST_SKIP: begin
        if ((word_valid && last_word) || timeout) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, frame counters and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      tgt_reg         <= '0;
      len_reg         <= '0;
      addr_reg        <= '0;
      wr_en_reg       <= 1'b0;
      wr_sel_reg      <= '0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      busy_reg        <= 1'b0;
      load_done_reg   <= 1'b0;
      done_tgt_reg    <= '0;
      start_infer_reg <= 1'b0;
      err_reg         <= 1'b0;
      err_code_reg    <= ERR_NONE;
    end else begin
      state_reg       <= state_next;
      wr_en_reg       <= 1'b0;
      wr_sel_reg      <= '0;
      load_done_reg   <= 1'b0;
      start_infer_reg <= 1'b0;
      err_reg         <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_FINISH: begin
          if (state_reg == ST_FINISH) begin
            load_done_reg   <= 1'b1;
            done_tgt_reg    <= tgt_reg;
            start_infer_reg <= (tgt_reg == TGT_IMG);
            busy_reg        <= 1'b0;
          end
          if (word_valid) begin
            if (hdr_code == ERR_NONE) begin
              err_code_reg <= ERR_NONE;
              tgt_reg      <= hdr_tgt[1:0];
              len_reg      <= hdr_len;
              addr_reg     <= '0;
              busy_reg     <= 1'b1;
            end else begin
              err_reg      <= 1'b1;
              err_code_reg <= hdr_code;
              if (hdr_code == ERR_BUSY) begin
                len_reg  <= hdr_len;
                addr_reg <= '0;
                busy_reg <= 1'b1;
              end
            end
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            wr_en_reg   <= 1'b1;
            wr_sel_reg  <= sel_onehot;
            wr_addr_reg <= addr_reg;
            wr_data_reg <= word;
            addr_reg    <= addr_reg + 1'b1;
          end else if (timeout) begin
            err_reg      <= 1'b1;
            err_code_reg <= ERR_TIMEOUT;
            busy_reg     <= 1'b0;
          end
        end
        ST_SKIP: begin
          if (word_valid) begin
            addr_reg <= addr_reg + 1'b1;
            if (last_word) busy_reg <= 1'b0;
          end else if (timeout) begin
            err_reg      <= 1'b1;
            err_code_reg <= ERR_TIMEOUT;
            busy_reg     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_en       = wr_en_reg;
  assign wr_sel      = wr_sel_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign busy        = busy_reg;
  assign load_done   = load_done_reg;
  assign done_tgt    = done_tgt_reg;
  assign start_infer = start_infer_reg;
  assign err         = err_reg;
  assign err_code    = err_code_reg;

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Self-checking bench for uart_load_ctrl: write scoreboard plus header-error
// vector table and hand-written frame sequences.
module tb_uart_load_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int N_TGT  = 4;
  localparam int TO     = 50;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              word_valid = 1'b0;
  logic [DATA_W-1:0] word = '0;
  logic              infer_busy = 1'b0;
  logic              wr_en;
  logic [N_TGT-1:0]  wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy, load_done, start_infer, err;
  logic [1:0]        done_tgt;
  logic [2:0]        err_code;

  uart_load_ctrl #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .N_TGT (N_TGT), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .rst_n (rst_n), .word_valid (word_valid), .word (word),
    .infer_busy (infer_busy), .wr_en (wr_en), .wr_sel (wr_sel),
    .wr_addr (wr_addr), .wr_data (wr_data), .busy (busy),
    .load_done (load_done), .done_tgt (done_tgt), .start_infer (start_infer),
    .err (err), .err_code (err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_TGT-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  typedef struct {
    logic [15:0] hdr;
    logic        ib;
    logic [2:0]  exp_code;
  } hdr_vec_t;

  wr_exp_t  exp_q[$];
  hdr_vec_t vecs[5];
  int       checks = 0;
  int       errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle; any write seen is matched against the scoreboard
  task automatic tick();
    wr_exp_t e;
    @(negedge clk);
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: sel=%b addr=%0d data=0x%h", wr_sel, wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_sel", 32'(wr_sel), 32'(e.sel));
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        $display("write sel=%b addr=%0d data=0x%h", wr_sel, wr_addr, wr_data);
      end
    end
  endtask

  task automatic send(input logic [15:0] w);
    word = w;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic push(input logic [N_TGT-1:0] s, input logic [ADDR_W-1:0] a, input logic [15:0] d);
    wr_exp_t e;
    e.sel = s; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Last payload word has just been sent: load_done one cycle after wr_en
  task automatic chk_done(input logic [1:0] tgt, input logic si);
    chk("load_done_early", 32'(load_done), 32'd0);
    tick();
    chk("load_done", 32'(load_done), 32'd1);
    chk("done_tgt", 32'(done_tgt), 32'(tgt));
    chk("start_infer", 32'(start_infer), 32'(si));
    chk("busy_after_done", 32'(busy), 32'd0);
    $display("frame done tgt=%0d start_infer=%0b", done_tgt, start_infer);
    tick();
    chk("load_done_pulse", 32'(load_done), 32'd0);
  endtask

  initial begin
    bit seen;
    int n;
    vecs[0] = '{16'h5001, 1'b0, 3'd1};
    vecs[1] = '{16'h1000, 1'b0, 3'd2};
    vecs[2] = '{16'h4001, 1'b0, 3'd1};
    vecs[3] = '{16'hF00A, 1'b1, 3'd1};
    vecs[4] = '{16'h0000, 1'b1, 3'd2};

    // Reset state
    repeat (3) tick();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_done_tgt", 32'(done_tgt), 0);
    rst_n = 1'b1;
    tick();

    // 1: three words to target 1
    send(16'h1003);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_err", 32'(err), 0);
    push(4'b0010, 0, 16'hAAAA); send(16'hAAAA);
    push(4'b0010, 1, 16'hBBBB); send(16'hBBBB);
    push(4'b0010, 2, 16'hCCCC); send(16'hCCCC);
    chk_done(2'd1, 1'b0);

    // 2: image load, start_infer with load_done
    infer_busy = 1'b0;
    send(16'h0002);
    push(4'b0001, 0, 16'h1234); send(16'h1234);
    push(4'b0001, 1, 16'h5678); send(16'h5678);
    chk_done(2'd0, 1'b1);

    // 3: image header while busy -> skip frame, then normal frame
    infer_busy = 1'b1;
    send(16'h0002);
    chk("t3_err", 32'(err), 1);
    chk("t3_code", 32'(err_code), 3);
    chk("t3_busy", 32'(busy), 1);
    send(16'h9999);
    send(16'h8888);
    chk("t3_busy_end", 32'(busy), 0);
    tick();
    chk("t3_no_done", 32'(load_done), 0);
    infer_busy = 1'b0;
    send(16'h2001);
    chk("t3_code_clr", 32'(err_code), 0);
    push(4'b0100, 0, 16'hDEAD); send(16'hDEAD);
    chk_done(2'd2, 1'b0);

    // 4: header error table
    for (int i = 0; i < 5; i++) begin
      infer_busy = vecs[i].ib;
      send(vecs[i].hdr);
      chk("hdr_err", 32'(err), 1);
      chk("hdr_code", 32'(err_code), 32'(vecs[i].exp_code));
      chk("hdr_busy", 32'(busy), 0);
      $display("header 0x%h ib=%0b -> err_code=%0d", vecs[i].hdr, vecs[i].ib, err_code);
      tick();
      chk("hdr_err_pulse", 32'(err), 0);
    end
    infer_busy = 1'b0;

    // 5: timeout after two of four words
    send(16'h1004);
    push(4'b0010, 0, 16'h0101); send(16'h0101);
    push(4'b0010, 1, 16'h0202); send(16'h0202);
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < TO + 10; i++) begin
      tick();
      n++;
      if (err) begin seen = 1'b1; break; end
    end
    chk("t5_timeout_seen", 32'(seen), 1);
    chk("t5_timeout_window", 32'((n >= TO - 2) && (n <= TO + 2)), 1);
    chk("t5_code", 32'(err_code), 4);
    chk("t5_busy", 32'(busy), 0);
    $display("timeout after %0d idle cycles code=%0d", n, err_code);
    send(16'h1001);
    chk("t5_code_clr", 32'(err_code), 0);
    push(4'b0010, 0, 16'h4242); send(16'h4242);
    chk_done(2'd1, 1'b0);

    // 6: asynchronous reset mid-load
    send(16'h1003);
    push(4'b0010, 0, 16'h5555); send(16'h5555);
    rst_n = 1'b0;
    #1;
    chk("t6_wr_en", 32'(wr_en), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_wr_data", 32'(wr_data), 0);
    chk("t6_done_tgt", 32'(done_tgt), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send(16'h3001);
    push(4'b1000, 0, 16'h7777); send(16'h7777);
    chk_done(2'd3, 1'b0);

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
